// File: rtl/wb_irq_dispatcher.sv
// Wishbone interrupt dispatcher: reads the controller status, masks the lowest
// pending source, presents it to a consumer and re-enables it once serviced.
module wb_irq_dispatcher #(
    parameter int unsigned WB_DWIDTH  = 32,
    parameter int unsigned WB_SWIDTH  = 4,
    parameter logic [31:0] IC_BASE    = 32'h1400_0000,
    parameter logic [15:0] STATUS_OFS = 16'h0000,
    parameter logic [15:0] ENSET_OFS  = 16'h0008,
    parameter logic [15:0] ENCLR_OFS  = 16'h000C
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_irq,
    output logic [31:0]          o_wb_adr,
    output logic [WB_SWIDTH-1:0] o_wb_sel,
    output logic                 o_wb_we,
    output logic [WB_DWIDTH-1:0] o_wb_dat,
    input  logic [WB_DWIDTH-1:0] i_wb_dat,
    output logic                 o_wb_cyc,
    output logic                 o_wb_stb,
    input  logic                 i_wb_ack,
    input  logic                 i_wb_err,
    output logic [4:0]           o_vec,
    output logic                 o_vec_valid,
    input  logic                 i_vec_ready,
    input  logic                 i_done,
    output logic                 o_busy,
    output logic [7:0]           o_spurious_cnt
);

    localparam int unsigned NLANES    = WB_DWIDTH / 32;
    localparam logic [31:0] ADR_STAT  = IC_BASE + {16'h0000, STATUS_OFS};
    localparam logic [31:0] ADR_SET   = IC_BASE + {16'h0000, ENSET_OFS};
    localparam logic [31:0] ADR_CLR   = IC_BASE + {16'h0000, ENCLR_OFS};
    localparam int unsigned LANE_STAT = (NLANES == 1) ? 0 : 32'(ADR_STAT[3:2]);

    typedef enum logic [2:0] {
        IDLE,
        RD_STAT,
        DECODE,
        WR_CLR,
        PRESENT,
        WAIT_DONE,
        WR_SET
    } state_t;

    state_t      state;
    logic        bus_q;
    logic [31:0] status_q;
    logic [4:0]  vec_q;
    logic [4:0]  low_idx;
    logic        unused_rd;

    // Byte selects for the 32-bit lane addressed by adr[3:2] on wide buses.
    function automatic logic [WB_SWIDTH-1:0] lane_sel(input logic [1:0] lane);
        if (NLANES == 1) return '1;
        return WB_SWIDTH'(4'hF) << {lane, 2'b00};
    endfunction

    assign o_wb_cyc  = bus_q;
    assign o_wb_stb  = bus_q;
    assign unused_rd = ^i_wb_dat;

    // Lowest-numbered pending source has priority.
    always_comb begin
        low_idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (status_q[i]) low_idx = 5'(i);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            bus_q          <= 1'b0;
            o_wb_we        <= 1'b0;
            o_wb_adr       <= '0;
            o_wb_sel       <= '0;
            o_wb_dat       <= '0;
            o_vec          <= '0;
            o_vec_valid    <= 1'b0;
            o_busy         <= 1'b0;
            o_spurious_cnt <= '0;
            status_q       <= '0;
            vec_q          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_irq) begin
                        state    <= RD_STAT;
                        o_busy   <= 1'b1;
                        bus_q    <= 1'b1;
                        o_wb_we  <= 1'b0;
                        o_wb_adr <= ADR_STAT;
                        o_wb_sel <= lane_sel(ADR_STAT[3:2]);
                    end
                end
                RD_STAT: begin
                    if (i_wb_err) begin
                        state  <= IDLE;
                        bus_q  <= 1'b0;
                        o_busy <= 1'b0;
                    end else if (i_wb_ack) begin
                        state    <= DECODE;
                        bus_q    <= 1'b0;
                        status_q <= i_wb_dat[32*LANE_STAT +: 32];
                    end
                end
                DECODE: begin
                    if (status_q == '0) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                        if (o_spurious_cnt != 8'hFF) o_spurious_cnt <= o_spurious_cnt + 8'd1;
                    end else begin
                        state    <= WR_CLR;
                        vec_q    <= low_idx;
                        bus_q    <= 1'b1;
                        o_wb_we  <= 1'b1;
                        o_wb_adr <= ADR_CLR;
                        o_wb_sel <= lane_sel(ADR_CLR[3:2]);
                        o_wb_dat <= {NLANES{32'd1 << low_idx}};
                    end
                end
                WR_CLR: begin
                    if (i_wb_err) begin
                        state   <= IDLE;
                        bus_q   <= 1'b0;
                        o_wb_we <= 1'b0;
                        o_busy  <= 1'b0;
                    end else if (i_wb_ack) begin
                        state       <= PRESENT;
                        bus_q       <= 1'b0;
                        o_wb_we     <= 1'b0;
                        o_vec       <= vec_q;
                        o_vec_valid <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (i_vec_ready) begin
                        state       <= WAIT_DONE;
                        o_vec_valid <= 1'b0;
                    end
                end
                WAIT_DONE: begin
                    if (i_done) begin
                        state    <= WR_SET;
                        bus_q    <= 1'b1;
                        o_wb_we  <= 1'b1;
                        o_wb_adr <= ADR_SET;
                        o_wb_sel <= lane_sel(ADR_SET[3:2]);
                        o_wb_dat <= {NLANES{32'd1 << vec_q}};
                    end
                end
                WR_SET: begin
                    if (i_wb_err || i_wb_ack) begin
                        state   <= IDLE;
                        bus_q   <= 1'b0;
                        o_wb_we <= 1'b0;
                        o_busy  <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus_q       <= 1'b0;
                    o_wb_we     <= 1'b0;
                    o_vec_valid <= 1'b0;
                    o_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_irq_dispatcher.sv
// Bench for wb_irq_dispatcher: scripted and random interrupt sequences against
// a Wishbone slave model and an expected-bus-log reference.
module tb_wb_irq_dispatcher;

    localparam logic [31:0] ADR_STAT = 32'h1400_0000;
    localparam logic [31:0] ADR_SET  = 32'h1400_0008;
    localparam logic [31:0] ADR_CLR  = 32'h1400_000C;

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic         i_irq, i_vec_ready, i_done;
    logic [31:0]  o_wb_adr;
    logic [3:0]   o_wb_sel;
    logic         o_wb_we, o_wb_cyc, o_wb_stb;
    logic [31:0]  o_wb_dat, i_wb_dat;
    logic         i_wb_ack, i_wb_err;
    logic [4:0]   o_vec;
    logic         o_vec_valid, o_busy;
    logic [7:0]   o_spurious_cnt;

    logic         irq_w, vec_ready_w, done_w;
    logic [31:0]  wb_adr_w;
    logic [15:0]  wb_sel_w;
    logic         wb_we_w, wb_cyc_w, wb_stb_w;
    logic [127:0] wb_dat_w, wb_rdat_w;
    logic         wb_ack_w, wb_err_w;
    logic [4:0]   vec_w;
    logic         vec_valid_w, busy_w;
    logic [7:0]   spur_w;

    int n_vec = 0;
    int n_mis = 0;
    int exp_spur = 0;
    int proto_bad = 0;
    int vv_cnt = 0;

    logic [31:0] slv_status = 32'h0;
    int          slv_lat = 1;
    int          err_on = 0;
    logic        err_with_ack = 1'b0;

    logic [31:0]  q_adr[$];
    logic         q_we[$];
    logic [31:0]  q_dat[$];
    logic [3:0]   q_sel[$];
    logic [31:0]  w_adr[$];
    logic [127:0] w_dat[$];
    logic [15:0]  w_sel[$];

    wb_irq_dispatcher u_dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_irq(i_irq),
        .o_wb_adr(o_wb_adr), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we),
        .o_wb_dat(o_wb_dat), .i_wb_dat(i_wb_dat), .o_wb_cyc(o_wb_cyc),
        .o_wb_stb(o_wb_stb), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
        .o_vec(o_vec), .o_vec_valid(o_vec_valid), .i_vec_ready(i_vec_ready),
        .i_done(i_done), .o_busy(o_busy), .o_spurious_cnt(o_spurious_cnt)
    );

    wb_irq_dispatcher #(.WB_DWIDTH(128), .WB_SWIDTH(16)) u_dut_w (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_irq(irq_w),
        .o_wb_adr(wb_adr_w), .o_wb_sel(wb_sel_w), .o_wb_we(wb_we_w),
        .o_wb_dat(wb_dat_w), .i_wb_dat(wb_rdat_w), .o_wb_cyc(wb_cyc_w),
        .o_wb_stb(wb_stb_w), .i_wb_ack(wb_ack_w), .i_wb_err(wb_err_w),
        .o_vec(vec_w), .o_vec_valid(vec_valid_w), .i_vec_ready(vec_ready_w),
        .i_done(done_w), .o_busy(busy_w), .o_spurious_cnt(spur_w)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // 32-bit slave: programmable wait states, optional error, logs every completed transfer.
    initial begin : slave32
        int  left;
        logic in_xfer;
        left = 0; in_xfer = 1'b0;
        i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_dat = '0;
        forever begin
            @(posedge i_clk); #1;
            if ((i_wb_ack || i_wb_err) && o_wb_stb) proto_bad++;
            if (o_wb_stb !== o_wb_cyc) proto_bad++;
            if (o_vec_valid) vv_cnt++;
            i_wb_ack = 1'b0; i_wb_err = 1'b0;
            if (o_wb_stb && i_rst_n) begin
                if (!in_xfer) begin in_xfer = 1'b1; left = slv_lat; end
                if (left == 0) begin
                    in_xfer = 1'b0;
                    if ((err_on == 1 && !o_wb_we) ||
                        (err_on == 2 && o_wb_we && o_wb_adr == ADR_CLR) ||
                        (err_on == 3 && o_wb_we && o_wb_adr == ADR_SET)) begin
                        i_wb_err = 1'b1;
                        i_wb_ack = err_with_ack;
                    end else begin
                        i_wb_ack = 1'b1;
                    end
                    if (!o_wb_we) i_wb_dat = slv_status;
                    q_adr.push_back(o_wb_adr); q_we.push_back(o_wb_we);
                    q_dat.push_back(o_wb_dat); q_sel.push_back(o_wb_sel);
                end else begin
                    left--;
                end
            end else begin
                in_xfer = 1'b0;
            end
        end
    end

    // 128-bit slave: acks in the strobe cycle; status sits in lane 0, decoys elsewhere.
    initial begin : slave128
        wb_ack_w = 1'b0; wb_err_w = 1'b0; wb_rdat_w = '0;
        forever begin
            @(posedge i_clk); #1;
            wb_ack_w = 1'b0;
            if (wb_stb_w && i_rst_n) begin
                wb_ack_w  = 1'b1;
                wb_rdat_w = {32'h1, 32'h1, 32'h1, 32'h100};
                w_adr.push_back(wb_adr_w); w_dat.push_back(wb_dat_w); w_sel.push_back(wb_sel_w);
            end
        end
    end

    task automatic chk_reset();
        chk("rst_stb", 128'(o_wb_stb), 128'(0));
        chk("rst_cyc", 128'(o_wb_cyc), 128'(0));
        chk("rst_we", 128'(o_wb_we), 128'(0));
        chk("rst_adr", 128'(o_wb_adr), 128'(0));
        chk("rst_sel", 128'(o_wb_sel), 128'(0));
        chk("rst_dat", 128'(o_wb_dat), 128'(0));
        chk("rst_vec", 128'(o_vec), 128'(0));
        chk("rst_valid", 128'(o_vec_valid), 128'(0));
        chk("rst_busy", 128'(o_busy), 128'(0));
        chk("rst_spur", 128'(o_spurious_cnt), 128'(0));
        chk("rst_stb_w", 128'(wb_stb_w), 128'(0));
    endtask

    // One interrupt episode; eo: 0 none, 1 error on status read, 2 on clear, 3 on set.
    task automatic run_irq(input logic [31:0] st, input int eo, input int rdy_dly);
        logic [31:0] iso;
        int          n, n_exp;
        logic        want_vec, got_vec, ended;
        iso = st & (~st + 32'd1);
        n   = (st == 32'h0) ? 0 : $clog2(iso);
        if (eo == 1 || st == 32'h0) n_exp = 1;
        else if (eo == 2)           n_exp = 2;
        else                        n_exp = 3;
        want_vec = (n_exp == 3);
        if (eo != 1 && st == 32'h0 && exp_spur < 255) exp_spur++;
        slv_status = st; err_on = eo; vv_cnt = 0;
        q_adr.delete(); q_we.delete(); q_dat.delete(); q_sel.delete();

        i_irq = 1'b1; @(negedge i_clk); i_irq = 1'b0;
        chk("busy_on_irq", 128'(o_busy), 128'(1));
        got_vec = 1'b0; ended = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (i_wb_err) begin
                @(negedge i_clk);
                chk("err_idle_busy", 128'(o_busy), 128'(0));
                chk("err_idle_valid", 128'(o_vec_valid), 128'(0));
                ended = 1'b1; break;
            end
            if (o_vec_valid) begin got_vec = 1'b1; ended = 1'b1; break; end
            if (!o_busy) begin ended = 1'b1; break; end
            @(negedge i_clk);
        end
        chk("seq_bounded", 128'(ended), 128'(1));
        chk("vec_presented", 128'(got_vec), 128'(want_vec));

        if (got_vec) begin
            chk("vec_num", 128'(o_vec), 128'(n));
            for (int c = 0; c < rdy_dly; c++) begin
                i_done = (c == 1 || c == 5);
                @(negedge i_clk);
                chk("valid_hold", 128'(o_vec_valid), 128'(1));
                chk("vec_hold", 128'(o_vec), 128'(n));
            end
            i_done = 1'b0; i_vec_ready = 1'b1;
            @(negedge i_clk); i_vec_ready = 1'b0;
            chk("valid_drop", 128'(o_vec_valid), 128'(0));
            repeat (2) @(negedge i_clk);
            chk("wait_done_busy", 128'(o_busy), 128'(1));
            chk("wait_done_nowr", 128'(q_adr.size()), 128'(2));
            i_done = 1'b1; @(negedge i_clk); i_done = 1'b0;
            ended = 1'b0;
            for (int c = 0; c < 20; c++) begin
                if (!o_busy) begin ended = 1'b1; break; end
                @(negedge i_clk);
            end
            chk("set_bounded", 128'(ended), 128'(1));
        end else begin
            chk("no_valid", 128'(vv_cnt), 128'(0));
        end

        chk("log_len", 128'(q_adr.size()), 128'(n_exp));
        for (int i = 0; i < n_exp && i < q_adr.size(); i++) begin
            chk("log_adr", 128'(q_adr[i]), 128'((i == 0) ? ADR_STAT : (i == 1) ? ADR_CLR : ADR_SET));
            chk("log_we", 128'(q_we[i]), 128'(i != 0));
            if (i != 0) begin
                chk("log_dat", 128'(q_dat[i]), 128'(iso));
                chk("log_sel", 128'(q_sel[i]), 128'(4'hF));
            end
        end
        chk("idle_after", 128'(o_busy), 128'(0));
        chk("spur_cnt", 128'(o_spurious_cnt), 128'(exp_spur));
        repeat (2) @(negedge i_clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int           mode, eo;
        logic [31:0]  st;
        logic         ok;
        logic [127:0] d;
        i_rst_n = 1'b0; i_irq = 1'b0; i_vec_ready = 1'b0; i_done = 1'b0;
        irq_w = 1'b0; vec_ready_w = 1'b0; done_w = 1'b0;
        repeat (3) @(negedge i_clk);
        chk_reset();
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // three empty status reads
        slv_lat = 1;
        repeat (3) run_irq(32'h0, 0, 0);
        chk("spur_three", 128'(o_spurious_cnt), 128'(3));

        run_irq(32'h0000_0044, 0, 0);
        run_irq(32'h0000_0044, 0, 10);
        slv_lat = 0;
        run_irq(32'h0000_0100, 2, 0);
        err_with_ack = 1'b1;
        run_irq(32'h0000_0100, 2, 0);
        run_irq(32'h0000_0008, 1, 0);
        run_irq(32'h8000_0000, 3, 0);
        err_with_ack = 1'b0;
        slv_lat = 2;
        run_irq(32'h8000_0000, 0, 2);
        run_irq(32'hFFFF_FFFF, 0, 1);

        for (int k = 0; k < 60; k++) begin
            mode = int'($urandom_range(0, 3));
            st = (mode == 0) ? 32'h0 : (mode == 1) ? (32'd1 << $urandom_range(0, 31)) : $urandom;
            eo = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
            slv_lat = int'($urandom_range(0, 2));
            err_with_ack = 1'($urandom_range(0, 1));
            run_irq(st, eo, int'($urandom_range(0, 4)));
        end

        slv_lat = 0;
        repeat (260) run_irq(32'h0, 0, 0);
        chk("spur_sat", 128'(o_spurious_cnt), 128'(255));

        // wide bus: lane selection on read, lane-shifted selects on writes
        irq_w = 1'b1; @(negedge i_clk); irq_w = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (vec_valid_w) begin ok = 1'b1; break; end
            @(negedge i_clk);
        end
        chk("w_valid", 128'(ok), 128'(1));
        chk("w_vec", 128'(vec_w), 128'(8));
        chk("w_log_clr_len", 128'(w_adr.size()), 128'(2));
        if (w_adr.size() >= 2) begin
            chk("w_clr_adr", 128'(w_adr[1]), 128'(ADR_CLR));
            chk("w_clr_sel", 128'(w_sel[1]), 128'(16'hF000));
            d = w_dat[1];
            chk("w_clr_top", 128'(d[127:96]), 128'(32'h100));
            chk("w_clr_dat", d, {4{32'h100}});
        end
        vec_ready_w = 1'b1; @(negedge i_clk); vec_ready_w = 1'b0;
        done_w = 1'b1; @(negedge i_clk); done_w = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (!busy_w) begin ok = 1'b1; break; end
            @(negedge i_clk);
        end
        chk("w_idle", 128'(ok), 128'(1));
        chk("w_log_set_len", 128'(w_adr.size()), 128'(3));
        if (w_adr.size() >= 3) begin
            chk("w_set_adr", 128'(w_adr[2]), 128'(ADR_SET));
            chk("w_set_sel", 128'(w_sel[2]), 128'(16'h0F00));
            chk("w_set_dat", w_dat[2], {4{32'h100}});
        end

        // reset while the status read is outstanding
        slv_lat = 6; slv_status = 32'h10; err_on = 0;
        q_adr.delete(); q_we.delete(); q_dat.delete(); q_sel.delete();
        i_irq = 1'b1; @(negedge i_clk); i_irq = 1'b0;
        chk("pre_rst_stb", 128'(o_wb_stb), 128'(1));
        #2 i_rst_n = 1'b0;
        #1 chk_reset();
        exp_spur = 0;
        @(negedge i_clk); i_rst_n = 1'b1;
        repeat (8) @(negedge i_clk);
        chk("rst_no_xfer", 128'(q_adr.size()), 128'(0));
        chk("rst_stay_idle", 128'(o_busy), 128'(0));
        slv_lat = 1;
        run_irq(32'h0000_0600, 0, 1);

        chk("bus_protocol", 128'(proto_bad), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
